// File: rtl/mem_sram_ctrl_if.sv
// Memory request/response port between the core and the SRAM controller.
//
// Handshake rule, valid/ready on both channels: a transfer happens on
// the rising clock edge when valid and ready are both high. The sender holds
// valid and payload stable until that edge. The receiver may raise or lower
// ready at any time. Valid never depends on ready.
//
// Signals
//   req_valid/req_ready    request channel (core -> controller)
//   req_addr[31:0]         byte address
//   req_we                 1 = write, 0 = read
//   req_be[3:0]            byte-lane enables, lane i = bits [8i+7:8i]
//   req_wdata[31:0]        write data
//   resp_valid/resp_ready  response channel (controller -> core)
//   resp_rdata[31:0]       read data (0 for writes)
// Modports: master = core side, slave = controller side.
interface mem_sram_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;

  modport master (
    output req_valid, req_addr, req_we, req_be, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_be, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/mem_sram_ctrl.sv
// mem_sram_ctrl: memory-side endpoint for the core's memory port.
// Takes one request at a time and runs it against a single-port synchronous
// SRAM for WAIT_STATES+1 chip-enable cycles. It returns exactly one response
// per request, in order.
//
// Ports
//   clk, rst     clock (rising edge), asynchronous active-high reset
//   mem          mem_sram_ctrl_if.slave request/response channels
//   sram_*       SRAM control, address, write data; sram_rdata is read data
//                valid the cycle after the last chip-enable edge
//   range_err    sticky out-of-range flag (always 0 unless range check built)
//   dbg_state    current FSM state (IDLE=0, ACCESS=1, RESP=2)
//
// Build option
//   MEM_SRAM_CTRL_RANGE_CHK_EN: when defined, addresses outside the
//   BASE_ADDR window skip the SRAM access, return rdata=0 and set range_err.
//   When undefined, the upper address bits are ignored and the SRAM aliases.
module mem_sram_ctrl #(
  parameter int          ADDR_W      = 20,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst,
  mem_sram_ctrl_if.slave    mem,
  output logic              sram_ce,
  output logic              sram_we,
  output logic [3:0]        sram_be,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,
  output logic              range_err,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                is_wr_q, is_wr_d;
  logic                rd_pend_q, rd_pend_d;
  logic                resp_valid_q, resp_valid_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                ce_q, ce_d;
  logic                we_q, we_d;
  logic [3:0]          be_q, be_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                range_err_q, range_err_d;

  logic                req_ready;
  logic                take;
  logic                in_range;

  // The low two bits are ignored (be selects the bytes). The upper bits matter
  // only when the range check is built in.
  logic                unused_addr_bits;
  assign unused_addr_bits = ^{mem.req_addr[1:0], mem.req_addr[31:ADDR_W+2]};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    is_wr_d      = is_wr_q;
    rd_pend_d    = rd_pend_q;
    resp_valid_d = resp_valid_q;
    rdata_d      = rdata_q;
    ce_d         = ce_q;
    we_d         = we_q;
    be_d         = be_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    range_err_d  = range_err_q;

    // A new request may also be taken in the cycle the response hands off.
    // That removes the idle bubble between back-to-back requests.
    req_ready = (state_q == IDLE) ||
                ((state_q == RESP) && resp_valid_q && mem.resp_ready);
    take      = mem.req_valid && req_ready;

`ifdef MEM_SRAM_CTRL_RANGE_CHK_EN
    in_range = (mem.req_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
`else
    in_range = 1'b1;
`endif

    case (state_q)
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          ce_d    = 1'b0;
          we_d    = 1'b0;
          state_d = RESP;
          if (is_wr_q) begin
            resp_valid_d = 1'b1;
            rdata_d      = 32'h0;
          end else begin
            // The SRAM presents read data one cycle after its last enabled
            // edge, so the data is sampled in the first RESP cycle.
            rd_pend_d = 1'b1;
          end
        end
      end
      RESP: begin
        if (rd_pend_q) begin
          rdata_d      = sram_rdata;
          rd_pend_d    = 1'b0;
          resp_valid_d = 1'b1;
        end else if (resp_valid_q && mem.resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: ;
    endcase

    // Accepting a request overrides the IDLE/RESP next-state chosen above.
    if (take) begin
      addr_d  = mem.req_addr[ADDR_W+1:2];
      be_d    = mem.req_be;
      wdata_d = mem.req_wdata;
      is_wr_d = mem.req_we;
      if (in_range) begin
        state_d = ACCESS;
        cnt_d   = 4'(WAIT_STATES);
        ce_d    = 1'b1;
        we_d    = mem.req_we;
      end else begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        rdata_d      = 32'h0;
        range_err_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      is_wr_q      <= 1'b0;
      rd_pend_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      rdata_q      <= 32'h0;
      ce_q         <= 1'b0;
      we_q         <= 1'b0;
      be_q         <= 4'h0;
      addr_q       <= '0;
      wdata_q      <= 32'h0;
      range_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      is_wr_q      <= is_wr_d;
      rd_pend_q    <= rd_pend_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      ce_q         <= ce_d;
      we_q         <= we_d;
      be_q         <= be_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      range_err_q  <= range_err_d;
    end
  end

  assign mem.req_ready  = req_ready;
  assign mem.resp_valid = resp_valid_q;
  assign mem.resp_rdata = rdata_q;
  assign sram_ce        = ce_q;
  assign sram_we        = we_q;
  assign sram_be        = be_q;
  assign sram_addr      = addr_q;
  assign sram_wdata     = wdata_q;
  assign range_err      = range_err_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Bench for mem_sram_ctrl. Three controllers with WAIT_STATES 0, 1 and 3 each
// drive their own SRAM model. The bench drives one of them at a time through
// a select mux. The reference is a word-addressed memory map plus timing
// rules (latency, chip-enable count) computed from the wait-state count.
module tb_mem_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sel;
  logic        req_valid, req_we, resp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;

  logic        ob_req_ready [3];
  logic        ob_resp_valid[3];
  logic [31:0] ob_rdata     [3];
  logic        ob_ce        [3];
  logic        ob_we        [3];
  logic [3:0]  ob_be        [3];
  logic [19:0] ob_addr      [3];
  logic [31:0] ob_wdata     [3];
  logic        ob_rerr      [3];
  logic [1:0]  ob_state     [3];

  logic        o_req_ready, o_resp_valid, o_ce, o_we, o_rerr;
  logic [31:0] o_rdata, o_wdata;
  logic [3:0]  o_be;
  logic [19:0] o_addr;
  logic [1:0]  o_state;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WS = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    mem_sram_ctrl_if bus ();
    logic        ce, we, rerr;
    logic [3:0]  be;
    logic [19:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [1:0]  st;
    logic [31:0] mem_arr [4096];

    assign bus.req_valid  = (sel == 2'(g)) ? req_valid : 1'b0;
    assign bus.req_addr   = req_addr;
    assign bus.req_we     = req_we;
    assign bus.req_be     = req_be;
    assign bus.req_wdata  = req_wdata;
    assign bus.resp_ready = (sel == 2'(g)) ? resp_ready : 1'b1;

    mem_sram_ctrl #(.ADDR_W(20), .WAIT_STATES(WS), .BASE_ADDR(32'h8000_0000)) u_dut (
      .clk(clk), .rst(rst), .mem(bus),
      .sram_ce(ce), .sram_we(we), .sram_be(be), .sram_addr(addr),
      .sram_wdata(wd), .sram_rdata(rd), .range_err(rerr), .dbg_state(st)
    );

    // Synchronous single-port SRAM: a write updates the enabled lanes, and a
    // read presents data after the enabled edge.
    initial begin
      rd = 32'h0;
      for (int i = 0; i < 4096; i++) mem_arr[i] = 32'h0;
    end
    always @(posedge clk) begin
      if (ce) begin
        if (we) begin
          for (int b = 0; b < 4; b++)
            if (be[b]) mem_arr[addr[11:0]][8*b +: 8] <= wd[8*b +: 8];
        end else begin
          rd <= mem_arr[addr[11:0]];
        end
      end
    end

    assign ob_req_ready[g]  = bus.req_ready;
    assign ob_resp_valid[g] = bus.resp_valid;
    assign ob_rdata[g]      = bus.resp_rdata;
    assign ob_ce[g]         = ce;
    assign ob_we[g]         = we;
    assign ob_be[g]         = be;
    assign ob_addr[g]       = addr;
    assign ob_wdata[g]      = wd;
    assign ob_rerr[g]       = rerr;
    assign ob_state[g]      = st;
  end

  assign o_req_ready  = ob_req_ready[sel];
  assign o_resp_valid = ob_resp_valid[sel];
  assign o_rdata      = ob_rdata[sel];
  assign o_ce         = ob_ce[sel];
  assign o_we         = ob_we[sel];
  assign o_be         = ob_be[sel];
  assign o_addr       = ob_addr[sel];
  assign o_wdata      = ob_wdata[sel];
  assign o_rerr       = ob_rerr[sel];
  assign o_state      = ob_state[sel];

  int          cyc = 0;
  int          ce_cnt = 0;
  logic [19:0] ce_addr = 20'h0;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (o_ce) begin ce_cnt++; ce_addr = o_addr; end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: a word-addressed memory per controller, plus address
  // decode rules.
  logic [31:0] ref_mem [int];
  bit          rerr_exp [3];

  function automatic int ws_of(input int s);
    return (s == 0) ? 0 : ((s == 1) ? 1 : 3);
  endfunction

  function automatic int key(input int s, input logic [31:0] a);
    return s * 1048576 + int'((a >> 2) & 32'h000F_FFFF);
  endfunction

  function automatic bit addr_in_range(input logic [31:0] a);
`ifdef MEM_SRAM_CTRL_RANGE_CHK_EN
    return (a >> 22) == (32'h8000_0000 >> 22);
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [31:0] ref_read(input int s, input logic [31:0] a);
    int k = key(s, a);
    return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
  endfunction

  task automatic ref_write(input int s, input logic [31:0] a, input logic [3:0] b,
                           input logic [31:0] d);
    logic [31:0] v = ref_read(s, a);
    for (int i = 0; i < 4; i++) if (b[i]) v[8*i +: 8] = d[8*i +: 8];
    ref_mem[key(s, a)] = v;
  endtask

  // Issue one request with resp_ready high. Returns the response data, the
  // number of rising edges from the accept edge through the edge after which
  // resp_valid is high (inclusive), and the number of chip-enable cycles.
  task automatic do_req(input logic [31:0] a, input logic w, input logic [3:0] b,
                        input logic [31:0] d, output logic [31:0] rdata,
                        output int lat, output int ces);
    int c0, guard;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_we = w; req_be = b; req_wdata = d;
    resp_ready = 1'b1;
    guard = 0;
    while (!o_req_ready && guard < 50) begin @(negedge clk); guard++; end
    if (!o_req_ready) chk("req_ready_timeout", 32'(o_req_ready), 32'h1);
    c0 = ce_cnt;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!o_resp_valid && lat < 40) begin lat++; @(negedge clk); end
    rdata = o_rdata;
    ces = ce_cnt - c0;
    @(posedge clk); #1;
  endtask

  task automatic txn(input string tag, input int s, input logic [31:0] a, input logic w,
                     input logic [3:0] b, input logic [31:0] d, output logic [31:0] rd);
    logic [31:0] exp_rd;
    int lat, ces, exp_lat, exp_ces;
    bit inr = addr_in_range(a);
    sel = 2'(s);
    exp_rd  = (!inr || w) ? 32'h0 : ref_read(s, a);
    exp_lat = !inr ? 1 : (w ? ws_of(s) + 2 : ws_of(s) + 3);
    exp_ces = inr ? ws_of(s) + 1 : 0;
    do_req(a, w, b, d, rd, lat, ces);
    chk($sformatf("%s_rdata", tag), rd, exp_rd);
    chk($sformatf("%s_latency", tag), 32'(lat), 32'(exp_lat));
    chk($sformatf("%s_ce_cycles", tag), 32'(ces), 32'(exp_ces));
    if (inr) chk($sformatf("%s_sram_addr", tag), 32'(ce_addr), 32'(20'(a >> 2)));
    if (inr && w) ref_write(s, a, b, d);
    if (!inr) rerr_exp[s] = 1'b1;
    chk($sformatf("%s_range_err", tag), 32'(o_rerr), 32'(rerr_exp[s]));
  endtask

  initial begin
    logic [31:0] rd, d0;
    logic [31:0] exp_q[$];
    int n, bad, issued, got, last_cyc;
    bit tk, gv;

    sel = 2'd1; rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_be = 4'h0;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1;
    rerr_exp[0] = 1'b0; rerr_exp[1] = 1'b0; rerr_exp[2] = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_req_ready", 32'(o_req_ready), 32'h1);
    chk("rst_resp_valid", 32'(o_resp_valid), 32'h0);
    chk("rst_ce", 32'(o_ce), 32'h0);
    chk("rst_we", 32'(o_we), 32'h0);
    chk("rst_be", 32'(o_be), 32'h0);
    chk("rst_addr", 32'(o_addr), 32'h0);
    chk("rst_wdata", o_wdata, 32'h0);
    chk("rst_range_err", 32'(o_rerr), 32'h0);
    chk("rst_state", 32'(o_state), 32'h0);
    rst = 1'b0;

    // Write then read back, one wait state
    txn("t1_wr", 1, 32'h8000_0010, 1'b1, 4'hF, 32'hCAFE_BABE, rd);
    chk("t1_wr_sram_addr_4", 32'(ce_addr), 32'h4);
    txn("t1_rd", 1, 32'h8000_0010, 1'b0, 4'hF, 32'h0, rd);
    chk("t1_rd_value", rd, 32'hCAFE_BABE);

    // Byte lanes
    txn("t2_wr_full", 1, 32'h8000_0020, 1'b1, 4'hF, 32'h1122_3344, rd);
    txn("t2_wr_b3", 1, 32'h8000_0020, 1'b1, 4'h8, 32'hAA00_0000, rd);
    txn("t2_rd", 1, 32'h8000_0020, 1'b0, 4'hF, 32'h0, rd);
    chk("t2_rd_value", rd, 32'hAA22_3344);
    txn("t2_wr_be0", 1, 32'h8000_0020, 1'b1, 4'h0, 32'hFFFF_FFFF, rd);
    txn("t2_rd_be0", 1, 32'h8000_0022, 1'b0, 4'hF, 32'h0, rd);

    // Backpressure with a second request queued behind the first
    sel = 2'd1;
    @(negedge clk);
    resp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_be = 4'hF;
    req_addr = 32'h8000_0010; req_wdata = 32'h0;
    chk("t3_ready_idle", 32'(o_req_ready), 32'h1);
    @(posedge clk); #1;
    req_addr = 32'h8000_0020;
    n = 0;
    @(negedge clk);
    while (!o_resp_valid && n < 40) begin n++; @(negedge clk); end
    d0 = o_rdata;
    chk("t3_first_rdata", d0, ref_read(1, 32'h8000_0010));
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      if (o_resp_valid !== 1'b1 || o_rdata !== d0 || o_req_ready !== 1'b0 || o_ce !== 1'b0)
        bad++;
    end
    chk("t3_hold_violations", 32'(bad), 32'h0);
    resp_ready = 1'b1;
    #1;
    chk("t3_ready_on_release", 32'(o_req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("t3_queued_in_access", 32'(o_state), 32'h1);
    chk("t3_queued_ce", 32'(o_ce), 32'h1);
    chk("t3_resp_dropped", 32'(o_resp_valid), 32'h0);
    n = 0;
    @(negedge clk);
    while (!o_resp_valid && n < 40) begin n++; @(negedge clk); end
    chk("t3_second_rdata", o_rdata, ref_read(1, 32'h8000_0020));
    @(posedge clk); #1;

    // Randomized traffic, one wait state
    for (int i = 0; i < 30; i++) begin
      logic [31:0] a = 32'h8000_0000 + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
      txn($sformatf("rnd%0d", i), 1, a, 1'($urandom_range(0, 1)),
          4'($urandom_range(0, 15)), $urandom, rd);
    end

    // Stream of 8 reads, zero wait states
    for (int i = 0; i < 8; i++)
      txn($sformatf("t4_pre%0d", i), 0, 32'h8000_0100 + 32'(i * 4), 1'b1, 4'hF, $urandom, rd);
    sel = 2'd0;
    @(posedge clk); #1;
    issued = 0; got = 0; last_cyc = 0;
    req_valid = 1'b1; req_we = 1'b0; req_be = 4'hF; req_addr = 32'h8000_0100;
    resp_ready = 1'b1;
    for (int it = 0; it < 100 && got < 8; it++) begin
      @(negedge clk);
      tk = req_valid && o_req_ready;
      gv = o_resp_valid && resp_ready;
      if (gv) begin
        chk($sformatf("t4_rdata%0d", got), o_rdata,
            (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_0000);
        if (got > 0) chk($sformatf("t4_gap%0d", got), 32'(cyc - last_cyc), 32'd3);
        last_cyc = cyc;
        got++;
      end
      if (tk) begin
        exp_q.push_back(ref_read(0, req_addr));
        issued++;
      end
      @(posedge clk); #1;
      if (tk) begin
        if (issued < 8) req_addr = 32'h8000_0100 + 32'(issued * 4);
        else req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    chk("t4_count", 32'(got), 32'd8);

    // Out-of-range access (aliases into the SRAM without the range check)
    txn("t6_wr", 1, 32'h8000_1000, 1'b1, 4'hF, 32'h5A5A_1234, rd);
    txn("t6_rd_oor", 1, 32'h0000_1000, 1'b0, 4'hF, 32'h0, rd);
    txn("t6_rd_after", 1, 32'h8000_0010, 1'b0, 4'hF, 32'h0, rd);

    // Reset during the second ACCESS cycle, three wait states
    txn("t5_pre", 2, 32'h8000_0040, 1'b1, 4'hF, 32'h0BAD_F00D, rd);
    sel = 2'd2;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_be = 4'h5;
    req_addr = 32'h8000_0040; req_wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("t5_ce_first", 32'(o_ce), 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("t5_state", 32'(o_state), 32'h0);
    chk("t5_ce", 32'(o_ce), 32'h0);
    chk("t5_we", 32'(o_we), 32'h0);
    chk("t5_be", 32'(o_be), 32'h0);
    chk("t5_addr", 32'(o_addr), 32'h0);
    chk("t5_wdata", o_wdata, 32'h0);
    chk("t5_resp_valid", 32'(o_resp_valid), 32'h0);
    chk("t5_req_ready", 32'(o_req_ready), 32'h1);
    sel = 2'd1;
    #1;
    chk("t5_range_err_cleared", 32'(o_rerr), 32'h0);
    rerr_exp[0] = 1'b0; rerr_exp[1] = 1'b0; rerr_exp[2] = 1'b0;
    sel = 2'd2;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (o_resp_valid !== 1'b0) bad++;
    end
    chk("t5_no_stale_resp", 32'(bad), 32'h0);
    txn("t5_rd", 2, 32'h8000_0040, 1'b0, 4'hF, 32'h0, rd);
    chk("t5_rd_value", rd, 32'h0BAD_F00D);
    txn("t5_wr", 2, 32'h8000_0044, 1'b1, 4'h3, 32'h1234_5678, rd);
    txn("t5_rd2", 2, 32'h8000_0044, 1'b0, 4'hF, 32'h0, rd);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
